// File: rtl/uart_cmd_frontend.sv
// Command front end for the UART core: synchronises the raw 7-bit pad bus,
// qualifies each command by stability and idle-arming, and applies it to registered outputs.
module uart_cmd_frontend #(
  parameter int          STABLE_CYCLES  = 4,
  parameter logic [7:0]  DEFAULT_PREDIV = 8'd12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] io_in7,
  output logic [7:0] io_txData,
  output logic       io_txValid,
  input  logic       io_txReady,
  output logic [4:0] io_config,
  output logic [7:0] io_prediv,
  output logic       io_predivLoad,
  output logic       io_resetCommandStrobe,
  output logic       io_overflow,
  output logic       io_seqError
);

  localparam logic [3:0] STABLE_MAX   = 4'(STABLE_CYCLES);
  localparam logic [1:0] CMD_DATA     = 2'd0;
  localparam logic [1:0] CMD_CONFIG   = 2'd1;
  localparam logic [1:0] CMD_PREDIV   = 2'd2;
  localparam logic [1:0] CMD_SPARE    = 2'd3;
  localparam logic [4:0] RESET_PAYLOAD = 5'b11000;

  typedef enum logic {WAIT_IDLE = 1'b0, ARMED = 1'b1} arm_state_t;

  arm_state_t state_reg, state_next;

  logic [6:0] sync1_reg, sync2_reg;
  logic [3:0] cnt_reg, cnt_next;
  logic       accept;
  logic       reached;

  logic [1:0] cmd;
  logic [4:0] payload;

  logic [7:0] tx_data_reg, tx_data_next;
  logic       tx_valid_reg, tx_valid_next;
  logic [4:0] config_reg, config_next;
  logic [7:0] prediv_reg, prediv_next;
  logic       prediv_load_reg, prediv_load_next;
  logic       strobe_reg, strobe_next;
  logic       overflow_reg, overflow_next;
  logic       seq_error_reg, seq_error_next;
  logic [3:0] data_lo_reg, data_lo_next;
  logic       data_lo_pend_reg, data_lo_pend_next;
  logic [3:0] prediv_lo_reg, prediv_lo_next;
  logic       prediv_lo_pend_reg, prediv_lo_pend_next;

  logic       byte_done;
  logic [7:0] byte_value;

  assign cmd     = sync2_reg[1:0];
  assign payload = sync2_reg[6:2];

  // Stability is judged between the two synchroniser stages so that the
  // accept edge lands exactly 2+STABLE_CYCLES cycles after the pads settle.
  always_comb begin
    if (sync1_reg != sync2_reg) begin
      cnt_next = 4'd0;
    end else if (cnt_reg == STABLE_MAX) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  assign reached = (cnt_next == STABLE_MAX) && (cnt_reg != STABLE_MAX);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      WAIT_IDLE: begin
        if ((cnt_next == STABLE_MAX) && (cmd == CMD_SPARE)) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (reached && (cmd != CMD_SPARE)) begin
          accept     = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= WAIT_IDLE;
      sync1_reg <= 7'd0;
      sync2_reg <= 7'd0;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      sync1_reg <= io_in7;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    tx_data_next        = tx_data_reg;
    tx_valid_next       = tx_valid_reg;
    config_next         = config_reg;
    prediv_next         = prediv_reg;
    prediv_load_next    = 1'b0;
    strobe_next         = 1'b0;
    overflow_next       = overflow_reg;
    seq_error_next      = seq_error_reg;
    data_lo_next        = data_lo_reg;
    data_lo_pend_next   = data_lo_pend_reg;
    prediv_lo_next      = prediv_lo_reg;
    prediv_lo_pend_next = prediv_lo_pend_reg;
    byte_done           = 1'b0;
    byte_value          = {payload[3:0], data_lo_reg};

    if (tx_valid_reg && io_txReady) begin
      tx_valid_next = 1'b0;
    end

    if (accept) begin
      case (cmd)
        CMD_DATA: begin
          if (!payload[4]) begin
            data_lo_next      = payload[3:0];
            data_lo_pend_next = 1'b1;
          end else if (data_lo_pend_reg) begin
            byte_done         = 1'b1;
            data_lo_pend_next = 1'b0;
          end else begin
            seq_error_next = 1'b1;
          end
        end
        CMD_PREDIV: begin
          if (!payload[4]) begin
            prediv_lo_next      = payload[3:0];
            prediv_lo_pend_next = 1'b1;
          end else if (prediv_lo_pend_reg) begin
            prediv_next         = {payload[3:0], prediv_lo_reg};
            prediv_load_next    = 1'b1;
            prediv_lo_pend_next = 1'b0;
          end else begin
            seq_error_next = 1'b1;
          end
        end
        CMD_CONFIG: begin
          if (payload == RESET_PAYLOAD) begin
            strobe_next         = 1'b1;
            config_next         = 5'd0;
            prediv_next         = DEFAULT_PREDIV;
            prediv_load_next    = 1'b1;
            tx_valid_next       = 1'b0;
            data_lo_pend_next   = 1'b0;
            prediv_lo_pend_next = 1'b0;
            overflow_next       = 1'b0;
            seq_error_next      = 1'b0;
          end else begin
            config_next = payload;
          end
        end
        default: ;
      endcase
    end

    // Single-entry buffer: refill allowed when empty or being drained this cycle.
    if (byte_done) begin
      if (!tx_valid_reg || io_txReady) begin
        tx_data_next  = byte_value;
        tx_valid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_reg        <= 8'd0;
      tx_valid_reg       <= 1'b0;
      config_reg         <= 5'd0;
      prediv_reg         <= DEFAULT_PREDIV;
      prediv_load_reg    <= 1'b0;
      strobe_reg         <= 1'b0;
      overflow_reg       <= 1'b0;
      seq_error_reg      <= 1'b0;
      data_lo_reg        <= 4'd0;
      data_lo_pend_reg   <= 1'b0;
      prediv_lo_reg      <= 4'd0;
      prediv_lo_pend_reg <= 1'b0;
    end else begin
      tx_data_reg        <= tx_data_next;
      tx_valid_reg       <= tx_valid_next;
      config_reg         <= config_next;
      prediv_reg         <= prediv_next;
      prediv_load_reg    <= prediv_load_next;
      strobe_reg         <= strobe_next;
      overflow_reg       <= overflow_next;
      seq_error_reg      <= seq_error_next;
      data_lo_reg        <= data_lo_next;
      data_lo_pend_reg   <= data_lo_pend_next;
      prediv_lo_reg      <= prediv_lo_next;
      prediv_lo_pend_reg <= prediv_lo_pend_next;
    end
  end

  assign io_txData             = tx_data_reg;
  assign io_txValid            = tx_valid_reg;
  assign io_config             = config_reg;
  assign io_prediv             = prediv_reg;
  assign io_predivLoad         = prediv_load_reg;
  assign io_resetCommandStrobe = strobe_reg;
  assign io_overflow           = overflow_reg;
  assign io_seqError           = seq_error_reg;

endmodule

// File: tb/tb_uart_cmd_frontend.sv
// Directed bench for uart_cmd_frontend: hand-computed expectations checked
// one cycle-offset after each clock edge.
module tb_uart_cmd_frontend;

  logic       clk;
  logic       reset;
  logic [6:0] io_in7;
  logic [7:0] io_txData;
  logic       io_txValid;
  logic       io_txReady;
  logic [4:0] io_config;
  logic [7:0] io_prediv;
  logic       io_predivLoad;
  logic       io_resetCommandStrobe;
  logic       io_overflow;
  logic       io_seqError;

  int checks = 0;
  int errors = 0;
  int pulses;

  uart_cmd_frontend #(.STABLE_CYCLES(4), .DEFAULT_PREDIV(8'd12)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .io_in7                (io_in7),
    .io_txData             (io_txData),
    .io_txValid            (io_txValid),
    .io_txReady            (io_txReady),
    .io_config             (io_config),
    .io_prediv             (io_prediv),
    .io_predivLoad         (io_predivLoad),
    .io_resetCommandStrobe (io_resetCommandStrobe),
    .io_overflow           (io_overflow),
    .io_seqError           (io_seqError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] C_DATA = 2'd0, C_CONFIG = 2'd1, C_PREDIV = 2'd2, C_SPARE = 2'd3;

  function automatic logic [6:0] enc(input logic [1:0] c, input logic [4:0] p);
    return {p, c};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    io_in7 = enc(C_SPARE, 5'd0);
    step(n);
  endtask

  // Full command: hold until accepted, then return to idle long enough to re-arm.
  task automatic send(input logic [1:0] c, input logic [4:0] p);
    io_in7 = enc(c, p);
    step(8);
    idle(8);
  endtask

  initial begin
    reset      = 1'b0;
    io_txReady = 1'b0;
    io_in7     = enc(C_SPARE, 5'd0);
    step(3);
    check("rst_txValid", 32'(io_txValid), 32'd0);
    check("rst_txData", 32'(io_txData), 32'h00);
    check("rst_prediv", 32'(io_prediv), 32'd12);
    check("rst_config", 32'(io_config), 32'd0);
    check("rst_flags", {28'd0, io_overflow, io_seqError, io_predivLoad, io_resetCommandStrobe}, 32'd0);
    reset = 1'b1;
    idle(8);

    // DATA 0xA5 with exact latency
    io_txReady = 1'b1;
    send(C_DATA, 5'h05);
    io_in7 = enc(C_DATA, 5'h1A);
    step(5);
    check("lat_before_valid", 32'(io_txValid), 32'd0);
    step(1);
    check("lat_valid", 32'(io_txValid), 32'd1);
    check("lat_data", 32'(io_txData), 32'hA5);
    step(1);
    check("valid_pulse_end", 32'(io_txValid), 32'd0);
    idle(8);

    // overflow with txReady low
    io_txReady = 1'b0;
    send(C_DATA, 5'h01);
    send(C_DATA, 5'h11);
    check("ovf_first_data", 32'(io_txData), 32'h11);
    check("ovf_first_valid", 32'(io_txValid), 32'd1);
    check("ovf_flag_clear", 32'(io_overflow), 32'd0);
    send(C_DATA, 5'h02);
    send(C_DATA, 5'h12);
    check("ovf_data_held", 32'(io_txData), 32'h11);
    check("ovf_flag_set", 32'(io_overflow), 32'd1);
    check("ovf_valid_held", 32'(io_txValid), 32'd1);
    io_txReady = 1'b1;
    step(1);
    check("ovf_consumed", 32'(io_txValid), 32'd0);

    // PREDIV 0x34
    send(C_PREDIV, 5'h04);
    check("prediv_lo_only", 32'(io_prediv), 32'd12);
    io_in7 = enc(C_PREDIV, 5'h13);
    step(5);
    check("prediv_load_early", 32'(io_predivLoad), 32'd0);
    step(1);
    check("prediv_value", 32'(io_prediv), 32'h34);
    check("prediv_load", 32'(io_predivLoad), 32'd1);
    step(1);
    check("prediv_load_single", 32'(io_predivLoad), 32'd0);
    idle(8);
    check("seq_before", 32'(io_seqError), 32'd0);
    send(C_PREDIV, 5'h1F);
    check("seq_prediv_hi", 32'(io_seqError), 32'd1);
    check("seq_prediv_kept", 32'(io_prediv), 32'h34);

    // CONFIG and reset command
    send(C_CONFIG, 5'b00111);
    check("config_7", 32'(io_config), 32'd7);
    io_in7 = enc(C_CONFIG, 5'b11000);
    step(6);
    check("rc_strobe", 32'(io_resetCommandStrobe), 32'd1);
    check("rc_config", 32'(io_config), 32'd0);
    check("rc_prediv", 32'(io_prediv), 32'd12);
    check("rc_load", 32'(io_predivLoad), 32'd1);
    check("rc_flags", {30'd0, io_overflow, io_seqError}, 32'd0);
    check("rc_txValid", 32'(io_txValid), 32'd0);
    step(1);
    check("rc_strobe_end", 32'(io_resetCommandStrobe), 32'd0);
    check("rc_load_end", 32'(io_predivLoad), 32'd0);
    idle(8);

    // long holds: one accept each
    io_in7 = enc(C_DATA, 5'h05);
    step(50);
    idle(8);
    io_in7 = enc(C_DATA, 5'h1C);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (io_txValid) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_data", 32'(io_txData), 32'hC5);
    check("hold_no_seq", 32'(io_seqError), 32'd0);
    idle(8);

    // short glitch must not be accepted
    io_in7 = enc(C_CONFIG, 5'b00011);
    step(2);
    idle(10);
    check("glitch_config", 32'(io_config), 32'd0);

    // reset between nibbles, hi nibble left on pads
    send(C_DATA, 5'h06);
    io_in7 = enc(C_DATA, 5'h19);
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(20);
    check("mid_rst_valid", 32'(io_txValid), 32'd0);
    check("mid_rst_seq", 32'(io_seqError), 32'd0);
    idle(8);
    send(C_DATA, 5'h19);
    check("mid_rst_reissue_seq", 32'(io_seqError), 32'd1);
    check("mid_rst_reissue_valid", 32'(io_txValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_frontend.md
Name: uart_cmd_frontend

Overview:
- Command front end sitting directly upstream of the UART core's 7-bit command bus.
- Takes raw io_in7 from the pads, synchronises and qualifies it, and turns each accepted command into registered outputs:
  - a transmit byte with valid/ready handshake,
  - a config register,
  - a prescaler value,
  - a one-cycle reset-command strobe.
- Bus encoding: cmd = io_in7[1:0] (0 DATA, 1 CONFIG, 2 PREDIV, 3 SPARE/idle); payload = io_in7[6:2].

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a command is accepted (range 1..15).
- DEFAULT_PREDIV, 8'd12, prescaler value after reset or reset command.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- io_in7  input  7  raw pad command bus (asynchronous to clk).
- io_txData  output  8  assembled transmit byte.
- io_txValid  output  1  transmit byte available.
- io_txReady  input  1  downstream accepts byte when high with io_txValid.
- io_config  output  5  last CONFIG payload.
- io_prediv  output  8  committed prescaler value.
- io_predivLoad  output  1  one-cycle pulse when io_prediv is updated.
- io_resetCommandStrobe  output  1  one-cycle pulse on CONFIG payload 5'b11000.
- io_overflow  output  1  sticky: transmit byte dropped.
- io_seqError  output  1  sticky: high nibble received with no pending low nibble.

Behaviour:
- Reset (reset=0, async), every output and every state bit:
  - io_txData=0, io_txValid=0, io_config=0, io_prediv=DEFAULT_PREDIV.
  - io_predivLoad=0, io_resetCommandStrobe=0, io_overflow=0, io_seqError=0.
  - Synchroniser flops=0, stability counter=0, armed=0, both pending-low-nibble flags clear.
- Synchroniser: 2-flop on all 7 bits.
- Stability counter:
  - Resets to 0 when the synchronised value differs from the previous one.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Arming states:
  - WAIT_IDLE (armed=0): goes to ARMED once the synchronised value equals cmd=SPARE and has been stable STABLE_CYCLES.
  - ARMED: an accept event fires on the edge where the counter reaches STABLE_CYCLES with cmd != SPARE. Then go to WAIT_IDLE.
  - Net effect: exactly one accept per command. The host must return to idle between commands, so repeating a command requires an intervening idle.
- Latency: outputs update exactly 2+STABLE_CYCLES clk cycles after the pad value settles (the accept edge).
- DATA command, low nibble (payload[4]=0): store payload[3:0], set data-lo-pending.
- DATA command, high nibble (payload[4]=1):
  - If data-lo-pending: byte={payload[3:0],lo}; clear pending.
  - Otherwise: set io_seqError and make no byte.
- Transmit buffer (1 entry) on byte completion:
  - io_txValid=0, or io_txReady=1 in the same cycle: load io_txData, io_txValid=1 (same-cycle consume and refill).
  - Otherwise: drop the byte, set io_overflow, leave io_txData unchanged.
- io_txValid clears on the cycle after io_txValid & io_txReady when no new byte completes. io_txData is held stable while io_txValid=1.
- PREDIV command, low nibble: store into the prediv staging register, set prediv-lo-pending.
- PREDIV command, high nibble:
  - If prediv-lo-pending: io_prediv={payload[3:0],staged}, pulse io_predivLoad one cycle, clear pending.
  - Otherwise: set io_seqError.
  - 8'd0 is a legal stored value; interpretation belongs downstream.
- CONFIG command, payload != 5'b11000: io_config=payload.
- CONFIG command, payload == 5'b11000 (reset command):
  - Pulse io_resetCommandStrobe one cycle.
  - io_config=0, io_prediv=DEFAULT_PREDIV with io_predivLoad pulse.
  - io_txValid=0, both pending flags cleared, io_overflow=0, io_seqError=0.
- SPARE command: never accepted, only arms.
- Async reset asserted mid-command discards all partial state. After release, WAIT_IDLE is entered, so a command already on the pads is not accepted until idle has been seen.

Test Plan:
- Reset, then SPARE for 8 cycles, then DATA lo 0x5, idle, DATA hi 0xA, io_txReady=1 -> io_txValid pulses with io_txData=0xA5, 6 cycles after the hi nibble settles (STABLE_CYCLES=4).
- Hold io_txReady=0; send bytes 0x11 then 0x22 -> io_txData stays 0x11, io_overflow=1; raise io_txReady -> 0x11 consumed, io_txValid drops next cycle.
- Send PREDIV lo 0x4, idle, PREDIV hi 0x3 -> io_prediv=0x34 with a single io_predivLoad pulse; a PREDIV hi with no preceding lo -> io_seqError=1, io_prediv unchanged.
- CONFIG payload 5'b00111 -> io_config=7; CONFIG 5'b11000 -> one-cycle io_resetCommandStrobe, io_config=0, io_prediv=12, io_overflow and io_seqError cleared.
- Hold DATA lo 0x5 for 50 cycles without idle -> exactly one accept. Glitch io_in7 for 2 cycles (below STABLE_CYCLES) -> no accept.
- Assert reset mid-way between lo and hi nibble; release with the hi nibble still on the pads -> no byte, no seqError until idle is seen and the command is reissued.
